// File: rtl/pixel_pkg.sv
// Shared types and helpers for the byte-stream to pixel path.
// Holds the byte-phase encoding, the pixel type and frame geometry arithmetic.
package pixel_pkg;

    localparam int BYTES_PER_PIXEL = 3;

    typedef enum logic [1:0] {
        B0,
        B1,
        B2
    } byte_phase_t;

    typedef logic [23:0] pixel_t;

    function automatic int lines_of(input int frame_bytes, input int width);
        return frame_bytes / (width * BYTES_PER_PIXEL);
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Column/row position of the next pixel to be emitted, with scanline and frame flags.
// Advances one pixel per i_step; wraps x at the line end and y at the frame end.
module pixel_pos_counter
    import pixel_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int LINES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_step,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic       o_line_end,
    output logic       o_frame_end
);

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(LINES - 1);

    logic [7:0] r_x;
    logic [7:0] r_y;
    logic       w_line_end;
    logic       w_frame_end;

    assign w_line_end  = (r_x == X_LAST);
    assign w_frame_end = w_line_end && (r_y == Y_LAST);

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_line_end  = w_line_end;
    assign o_frame_end = w_frame_end;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_step) begin
            if (w_line_end) begin
                r_x <= '0;
                r_y <= w_frame_end ? '0 : r_y + 8'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

endmodule

// File: rtl/pixel_collector.sv
// Rebuilds a byte stream into addressed 24-bit RGB pixels behind a one-deep output register.
// Bytes 0/1 of the next pixel may be gathered while an output is held; byte 2 waits for consumption.
module pixel_collector
    import pixel_pkg::*;
#(
    parameter int scanline_width = 6,
    parameter int size           = 6 * 3 * 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        i_ready,
    output pixel_t      o_pixel,
    output logic [7:0]  o_x,
    output logic [7:0]  o_y,
    output logic        o_valid,
    output logic        line_end,
    output logic        frame_end,
    output logic        d_ok,
    output logic [15:0] led
);

    localparam int LINES = lines_of(size, scanline_width);

    if (scanline_width < 1 || scanline_width > 256 ||
        (size % (scanline_width * BYTES_PER_PIXEL)) != 0 ||
        LINES < 1 || LINES > 256) begin : g_bad_geometry
        $error("pixel_collector: size must be a whole number (1..256) of scanlines");
    end

    byte_phase_t r_phase;
    byte_phase_t w_phase_next;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic        w_accept;
    logic        w_consume;
    logic        w_load;
    logic [7:0]  w_x;
    logic [7:0]  w_y;
    logic        w_line_end;
    logic        w_frame_end;

    assign i_ready   = !o_valid || ena || (r_phase != B2);
    assign w_accept  = i_valid && i_ready;
    assign w_consume = o_valid && ena;
    assign w_load    = w_accept && (r_phase == B2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= B0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_phase_next = r_phase;
        if (w_accept) begin
            case (r_phase)
                B0:      w_phase_next = B1;
                B1:      w_phase_next = B2;
                default: w_phase_next = B0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte0 <= '0;
            r_byte1 <= '0;
        end else if (w_accept) begin
            if (r_phase == B0) r_byte0 <= i_data;
            if (r_phase == B1) r_byte1 <= i_data;
        end
    end

    pixel_pos_counter #(
        .WIDTH(scanline_width),
        .LINES(LINES)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_step     (w_load),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_line_end (w_line_end),
        .o_frame_end(w_frame_end)
    );

    // A load on the same edge as a consumption simply replaces the held pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pixel   <= '0;
            o_x       <= '0;
            o_y       <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
            o_valid   <= 1'b0;
        end else if (w_load) begin
            o_pixel   <= {r_byte0, r_byte1, i_data};
            o_x       <= w_x;
            o_y       <= w_y;
            line_end  <= w_line_end;
            frame_end <= w_frame_end;
            o_valid   <= 1'b1;
        end else if (w_consume) begin
            o_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_ok <= 1'b0;
            led  <= '0;
        end else begin
            d_ok <= w_consume && frame_end;
            if (w_consume && frame_end) led <= led + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_collector.sv
// Self-checking bench for pixel_collector: per-cycle reference model plus table and corner sequences.
module tb_pixel_collector;

    localparam int W     = 6;
    localparam int SZ    = 54;
    localparam int LINES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [23:0] o_pixel;
    logic [7:0]  o_x;
    logic [7:0]  o_y;
    logic        o_valid;
    logic        line_end;
    logic        frame_end;
    logic        d_ok;
    logic [15:0] led;

    always #5 clk = ~clk;

    pixel_collector #(
        .scanline_width(W),
        .size          (SZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .o_pixel  (o_pixel),
        .o_x      (o_x),
        .o_y      (o_y),
        .o_valid  (o_valid),
        .line_end (line_end),
        .frame_end(frame_end),
        .d_ok     (d_ok),
        .led      (led)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: accepted bytes since reset, pixels consumed, frames completed.
    logic [7:0]  acc_q[$];
    logic [7:0]  stim[$];
    int          consumed;
    int          frames;
    logic        exp_dok;
    int          dok_seen;
    logic [23:0] cap_pix[$];
    int          cap_x[$];
    int          cap_y[$];
    logic        cap_le[$];
    logic        cap_fe[$];

    typedef struct {
        int          idx;
        logic [23:0] pix;
        int          x;
        int          y;
        logic        le;
        logic        fe;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        acc_q.delete();
        cap_pix.delete();
        cap_x.delete();
        cap_y.delete();
        cap_le.delete();
        cap_fe.delete();
        consumed = 0;
        frames   = 0;
        exp_dok  = 1'b0;
        dok_seen = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_valid"},   o_valid,   0);
        check({tag, "_o_pixel"},   o_pixel,   0);
        check({tag, "_o_x"},       o_x,       0);
        check({tag, "_o_y"},       o_y,       0);
        check({tag, "_line_end"},  line_end,  0);
        check({tag, "_frame_end"}, frame_end, 0);
        check({tag, "_d_ok"},      d_ok,      0);
        check({tag, "_led"},       led,       0);
        check({tag, "_i_ready"},   i_ready,   1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_valid = 1'b0;
        ena     = 1'b0;
        rst     = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic fill_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'((i % 255) + 1));
    endtask

    // ena_mode: 0 always on, 1 toggling, 2 random, 3 low for 10 cycles then on.
    // valid_mode: 0 continuous, 1 random gaps.
    task automatic run(input int ena_mode, input int valid_mode, input int limit);
        int   cyc;
        int   idle;
        int   k;
        int   xe;
        int   ye;
        logic le;
        logic fe;
        logic exp_valid;
        logic exp_ready;
        logic next_dok;
        cyc  = 0;
        idle = 0;
        while (cyc < limit && idle < 3) begin
            @(negedge clk);
            case (ena_mode)
                0:       ena = 1'b1;
                1:       ena = (cyc % 2) == 1;
                2:       ena = 1'($urandom_range(0, 1));
                default: ena = (cyc >= 10);
            endcase
            if (acc_q.size() < stim.size()) begin
                i_valid = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                i_data  = stim[acc_q.size()];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            exp_valid = (acc_q.size() / 3) > consumed;
            exp_ready = !exp_valid || ena || ((acc_q.size() % 3) != 2);
            check("o_valid", o_valid, exp_valid);
            check("i_ready", i_ready, exp_ready);
            check("d_ok",    d_ok,    exp_dok);
            check("led",     led,     frames % 65536);
            if (d_ok === 1'b1) dok_seen++;
            next_dok = 1'b0;
            if (exp_valid && ena) begin
                k  = consumed;
                xe = k % W;
                ye = (k / W) % LINES;
                le = (xe == W - 1);
                fe = le && (ye == LINES - 1);
                check("o_pixel",   o_pixel,   {acc_q[3*k], acc_q[3*k+1], acc_q[3*k+2]});
                check("o_x",       o_x,       xe);
                check("o_y",       o_y,       ye);
                check("line_end",  line_end,  le);
                check("frame_end", frame_end, fe);
                cap_pix.push_back(o_pixel);
                cap_x.push_back(int'(o_x));
                cap_y.push_back(int'(o_y));
                cap_le.push_back(line_end);
                cap_fe.push_back(frame_end);
                next_dok = fe;
                if (fe) frames++;
                consumed++;
            end
            if (i_valid && exp_ready) acc_q.push_back(i_data);
            exp_dok = next_dok;
            if (acc_q.size() >= stim.size() && consumed * 3 >= stim.size()) idle++;
            cyc++;
        end
        i_valid = 1'b0;
        check("run_complete", consumed, stim.size() / 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{idx: 0,  pix: 24'h010203, x: 0, y: 0, le: 1'b0, fe: 1'b0};
        vecs[1] = '{idx: 5,  pix: 24'h101112, x: 5, y: 0, le: 1'b1, fe: 1'b0};
        vecs[2] = '{idx: 6,  pix: 24'h131415, x: 0, y: 1, le: 1'b0, fe: 1'b0};
        vecs[3] = '{idx: 11, pix: 24'h222324, x: 5, y: 1, le: 1'b1, fe: 1'b0};
        vecs[4] = '{idx: 17, pix: 24'h343536, x: 5, y: 2, le: 1'b1, fe: 1'b1};

        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Continuous stream
        fill_stim(SZ);
        run(0, 0, 500);
        check("cont_count", cap_pix.size(), 18);
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].idx < cap_pix.size()) begin
                check($sformatf("cont_pix%0d", vecs[i].idx), cap_pix[vecs[i].idx], vecs[i].pix);
                check($sformatf("cont_x%0d",   vecs[i].idx), cap_x[vecs[i].idx],   vecs[i].x);
                check($sformatf("cont_y%0d",   vecs[i].idx), cap_y[vecs[i].idx],   vecs[i].y);
                check($sformatf("cont_le%0d",  vecs[i].idx), cap_le[vecs[i].idx],  vecs[i].le);
                check($sformatf("cont_fe%0d",  vecs[i].idx), cap_fe[vecs[i].idx],  vecs[i].fe);
            end else begin
                check($sformatf("cont_missing%0d", vecs[i].idx), cap_pix.size(), vecs[i].idx + 1);
            end
        end
        check("cont_led", led, 1);
        check("cont_dok_pulses", dok_seen, 1);

        // ena toggling every cycle
        apply_reset();
        run(1, 0, 1000);
        check("toggle_count", cap_pix.size(), 18);
        check("toggle_led", led, 1);

        // Random i_valid gaps
        apply_reset();
        run(0, 1, 2000);
        check("gaps_count", cap_pix.size(), 18);
        if (cap_pix.size() == 18) check("gaps_last_pix", cap_pix[17], 24'h343536);

        // Random ena and random gaps together
        apply_reset();
        run(2, 1, 3000);
        check("rand_count", cap_pix.size(), 18);

        // Reset mid-pixel with a previously loaded, non-zero output register
        @(negedge clk);
        ena     = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h11;
        @(negedge clk);
        i_data  = 8'h22;
        @(negedge clk);
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("midpix");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        stim.delete();
        stim.push_back(8'hAA);
        stim.push_back(8'hBB);
        stim.push_back(8'hCC);
        run(0, 0, 100);
        check("midpix_count", cap_pix.size(), 1);
        if (cap_pix.size() >= 1) begin
            check("midpix_pix", cap_pix[0], 24'hAABBCC);
            check("midpix_x",   cap_x[0],   0);
            check("midpix_y",   cap_y[0],   0);
        end

        // Two back-to-back frames
        apply_reset();
        fill_stim(2 * SZ);
        run(0, 0, 1000);
        check("two_count", cap_pix.size(), 36);
        if (cap_pix.size() == 36) begin
            check("two_f2_x", cap_x[18], 0);
            check("two_f2_y", cap_y[18], 0);
            check("two_f2_fe", cap_fe[35], 1);
        end
        check("two_dok_pulses", dok_seen, 2);
        check("two_led", led, 2);

        // Held output, then consume and load on the same edge
        apply_reset();
        fill_stim(SZ);
        run(3, 0, 500);
        check("hold_count", cap_pix.size(), 18);
        if (cap_pix.size() >= 2) begin
            check("hold_pix0", cap_pix[0], 24'h010203);
            check("hold_pix1", cap_pix[1], 24'h040506);
        end
        check("hold_led", led, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
